uart_rx_fifo: RTL and testbench

- Receive buffer between the UART receiver and the CPU peripheral bus.
- Drains each byte from the UART's valid/rd handshake into a FIFO, so software can fall behind by up to DEPTH bytes without losing data.
- Presents the head byte and occupancy/status flags to the address decoder for the UART data and status registers.
- Sticky overflow flag records any dropped byte.

---
 rtl/uart_rx_fifo.sv | 96 +++++++++
 tb/tb_uart_rx_fifo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures one byte per UART valid/rd handshake into a FWFT FIFO.
// Optional RTS flow control with 1-entry hysteresis is enabled by `define UART_RX_FIFO_RTS_EN.
module uart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int RTS_LEVEL = 12
) (
    input  logic                     clk,
    input  logic                     reset_i,
    input  logic                     uart_valid_i,
    input  logic [7:0]               uart_data_i,
    output logic                     uart_rd_o,
    input  logic                     rd_strobe_i,
    input  logic                     clr_ovf_i,
    output logic [7:0]               data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     not_empty_o,
    output logic                     full_o,
`ifdef UART_RX_FIFO_RTS_EN
    output logic                     rts_n_o,
`endif
    output logic                     overflow_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_WAIT} state_t;

    state_t         state_q, state_d;
    logic [7:0]     mem [DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic           full_q, not_empty_q, ovf_q;
    logic           capture, push, pop, drop;

    // A full FIFO still accepts the byte when the CPU frees a slot on the same edge.
    assign capture = (state_q == S_CAPTURE);
    assign push    = capture && (!full_q || rd_strobe_i);
    assign drop    = capture && full_q && !rd_strobe_i;
    assign pop     = rd_strobe_i && not_empty_q;
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_comb begin
        state_d   = state_q;
        uart_rd_o = 1'b0;
        case (state_q)
            S_IDLE:    if (uart_valid_i) state_d = S_CAPTURE;
            S_CAPTURE: begin
                uart_rd_o = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT:    if (!uart_valid_i) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            not_empty_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q     <= count_d;
            full_q      <= (count_d == CW'(DEPTH));
            not_empty_q <= (count_d != '0);
            if (drop)           ovf_q <= 1'b1;
            else if (clr_ovf_i) ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= uart_data_i;
    end

`ifdef UART_RX_FIFO_RTS_EN
    logic rts_q;
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i)                            rts_q <= 1'b0;
        else if (int'(count_d) >= RTS_LEVEL)    rts_q <= 1'b1;
        else if (int'(count_d) + 2 <= RTS_LEVEL) rts_q <= 1'b0;
    end
    assign rts_n_o = rts_q;
`endif

    assign data_o      = not_empty_q ? mem[rd_ptr_q] : 8'h00;
    assign count_o     = count_q;
    assign not_empty_o = not_empty_q;
    assign full_o      = full_q;
    assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: accepted bytes are queued at issue time and
// compared by a monitor whenever the CPU pops a non-empty FIFO.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int RTS_LEVEL = 12;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       uart_valid_i;
    logic [7:0] uart_data_i;
    logic       uart_rd_o;
    logic       rd_strobe_i;
    logic       clr_ovf_i;
    logic [7:0] data_o;
    logic [4:0] count_o;
    logic       not_empty_o;
    logic       full_o;
    logic       overflow_o;
`ifdef UART_RX_FIFO_RTS_EN
    logic       rts_n_o;
`endif

    uart_rx_fifo #(.DEPTH(DEPTH), .RTS_LEVEL(RTS_LEVEL)) dut (
        .clk(clk), .reset_i(reset_i),
        .uart_valid_i(uart_valid_i), .uart_data_i(uart_data_i), .uart_rd_o(uart_rd_o),
        .rd_strobe_i(rd_strobe_i), .clr_ovf_i(clr_ovf_i),
        .data_o(data_o), .count_o(count_o), .not_empty_o(not_empty_o), .full_o(full_o),
`ifdef UART_RX_FIFO_RTS_EN
        .rts_n_o(rts_n_o),
`endif
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    int exp_pulses = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every effective pop must present the oldest accepted byte.
    always @(negedge clk) begin
        if (uart_rd_o === 1'b1) pulses++;
        if (!reset_i && rd_strobe_i && not_empty_o) begin
            if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
            else chk("pop_data", int'(data_o), int'(exp_q.pop_front()));
        end
    end

    task automatic send_byte(input logic [7:0] b, input int hold, input bit accept);
        @(posedge clk); #1;
        uart_valid_i = 1'b1; uart_data_i = b;
        if (accept) exp_q.push_back(b);
        exp_pulses++;
        repeat (hold) @(posedge clk);
        #1 uart_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pop1();
        @(posedge clk); #1 rd_strobe_i = 1'b1;
        @(posedge clk); #1 rd_strobe_i = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, int'(count_o), 0);
        chk({tag, "_data"}, int'(data_o), 0);
        chk({tag, "_not_empty"}, int'(not_empty_o), 0);
        chk({tag, "_full"}, int'(full_o), 0);
        chk({tag, "_ovf"}, int'(overflow_o), 0);
        chk({tag, "_rd"}, int'(uart_rd_o), 0);
`ifdef UART_RX_FIFO_RTS_EN
        chk({tag, "_rts"}, int'(rts_n_o), 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1; uart_valid_i = 1'b0; uart_data_i = 8'h00;
        rd_strobe_i = 1'b0; clr_ovf_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        reset_i = 1'b0;

        // Three bytes with valid held for 5 cycles: one rd pulse each.
        send_byte(8'h41, 5, 1);
        send_byte(8'h42, 5, 1);
        send_byte(8'h43, 5, 1);
        chk("rd_pulses_3", pulses, 3);
        chk("count_3", int'(count_o), 3);
        chk("head_41", int'(data_o), 8'h41);
        chk("not_empty_3", int'(not_empty_o), 1);
        repeat (3) pop1();
        chk("count_drained", int'(count_o), 0);
        chk("data_empty", int'(data_o), 0);

        // Fill, then overflow with 0xAA.
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 2, 1);
        chk("full", int'(full_o), 1);
        chk("count_full", int'(count_o), DEPTH);
        send_byte(8'hAA, 2, 0);
        chk("ovf_set", int'(overflow_o), 1);
        chk("rd_pulse_on_drop", pulses, exp_pulses);
        chk("count_after_drop", int'(count_o), DEPTH);
        chk("head_after_drop", int'(data_o), 8'h00);
        @(posedge clk); #1 clr_ovf_i = 1'b1;
        @(posedge clk); #1 clr_ovf_i = 1'b0;
        chk("ovf_cleared", int'(overflow_o), 0);

        // Full FIFO, CPU pops in the CAPTURE cycle of 0x55: byte is accepted.
        @(posedge clk); #1;
        uart_valid_i = 1'b1; uart_data_i = 8'h55;
        exp_q.push_back(8'h55); exp_pulses++;
        @(posedge clk); #1 rd_strobe_i = 1'b1;
        chk("rd_in_capture", int'(uart_rd_o), 1);
        @(posedge clk); #1 rd_strobe_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 uart_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("ovf_not_set_55", int'(overflow_o), 0);
        chk("count_stays_full", int'(count_o), DEPTH);
        repeat (DEPTH) pop1();
        chk("queue_drained", exp_q.size(), 0);
        chk("count_empty2", int'(count_o), 0);

        // Pop on empty is ignored.
        pop1();
        chk("empty_pop_count", int'(count_o), 0);
        chk("empty_pop_data", int'(data_o), 0);
        send_byte(8'h7E, 1, 1);
        chk("count_7e", int'(count_o), 1);
        chk("head_7e", int'(data_o), 8'h7E);
        pop1();

        // Pointer wrap: 40 push/pop pairs.
        for (int i = 0; i < 40; i++) begin
            send_byte(8'(8'h80 + i), 1, 1);
            pop1();
        end
        chk("wrap_drained", exp_q.size(), 0);
        chk("wrap_count", int'(count_o), 0);
        chk("rd_pulses_total", pulses, exp_pulses);

        // Async reset while in CAPTURE with 5 bytes stored.
        for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i), 1, 1);
        chk("count_5", int'(count_o), 5);
        @(posedge clk); #1;
        uart_valid_i = 1'b1; uart_data_i = 8'h99;
        @(posedge clk); #1;
        chk("in_capture", int'(uart_rd_o), 1);
        #1 reset_i = 1'b1;
        #1 chk_reset_state("async_rst");
        exp_q.delete();
        @(posedge clk); #1;
        @(negedge clk); #1 reset_i = 1'b0;
        exp_q.push_back(8'h99); exp_pulses++;
        repeat (3) @(posedge clk);
        #1;
        chk("recapture_count", int'(count_o), 1);
        chk("recapture_data", int'(data_o), 8'h99);
        chk("recapture_pulse", pulses, exp_pulses);
        uart_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        pop1();
        chk("count_after_recapture", int'(count_o), 0);

`ifdef UART_RX_FIFO_RTS_EN
        for (int i = 0; i < RTS_LEVEL - 1; i++) send_byte(8'(8'h20 + i), 1, 1);
        chk("rts_below", int'(rts_n_o), 0);
        send_byte(8'h2B, 1, 1);
        chk("rts_at_level", int'(rts_n_o), 1);
        pop1();
        chk("rts_hyst_11", int'(rts_n_o), 1);
        pop1();
        chk("rts_release_10", int'(rts_n_o), 0);
        repeat (RTS_LEVEL - 2) pop1();
        chk("rts_drained", exp_q.size(), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
